// File: rtl/dmi_pkg.sv
// DMI word definitions shared by the debug-channel buffer.
// Word layout is {addr[6:0], data[31:0], op[1:0]}.
package dmi_pkg;

  localparam int DMI_DATA_WIDTH = 41;
  localparam int DMI_ADDR_WIDTH = 7;

  typedef enum logic [1:0] {
    DMI_NOP   = 2'd0,
    DMI_READ  = 2'd1,
    DMI_WRITE = 2'd2
  } dmi_op_e;

  typedef struct packed {
    logic [DMI_ADDR_WIDTH-1:0] addr;
    logic [31:0]               data;
    dmi_op_e                   op;
  } dmi_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and registered storage.
// Read data is the head entry; nothing bypasses from write to read.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dmi_chan_buf.sv
// DMI request/response buffer between the debugger bridge and the DM.
// Limits issued requests and drops responses nobody is waiting for.
module dmi_chan_buf
  import dmi_pkg::*;
#(
  parameter int DATA_WIDTH      = DMI_DATA_WIDTH,
  parameter int REQ_DEPTH       = 4,
  parameter int RESP_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int OW = $clog2(MAX_OUTSTANDING + 1),
  localparam int QW = $clog2(REQ_DEPTH) + 1,
  localparam int RW = $clog2(RESP_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] core_req_data_o,
  output logic                  core_req_valid_o,
  input  logic                  core_req_ready_i,
  input  logic [DATA_WIDTH-1:0] core_resp_data_i,
  input  logic                  core_resp_valid_i,
  output logic                  core_resp_ready_o,
  output logic [OW-1:0]         outstanding_o,
  output logic                  unexp_resp_o
);

  if ((MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > RESP_DEPTH)) begin : g_bad_max
    $error("MAX_OUTSTANDING must be within 1..RESP_DEPTH");
  end
  if ((REQ_DEPTH < 2) || ((REQ_DEPTH & (REQ_DEPTH - 1)) != 0)) begin : g_bad_req
    $error("REQ_DEPTH must be a power of two >= 2");
  end
  if ((RESP_DEPTH < 2) || ((RESP_DEPTH & (RESP_DEPTH - 1)) != 0)) begin : g_bad_resp
    $error("RESP_DEPTH must be a power of two >= 2");
  end

  localparam logic [OW-1:0] MAX_OS = OW'(MAX_OUTSTANDING);

  logic          req_full;
  logic          req_empty;
  logic [QW-1:0] req_count;
  logic          resp_full;
  logic          resp_empty;
  logic [RW-1:0] resp_count;
  logic          req_push;
  logic          req_pop;
  logic          cresp_hs;
  logic          resp_push;
  logic          resp_pop;
  logic          pending_nz;

  assign req_ready_o       = !req_full && !flush_i;
  assign core_req_valid_o  = !req_empty && (outstanding_o < MAX_OS) && !flush_i;
  assign core_resp_ready_o = !resp_full && !flush_i;
  assign resp_valid_o      = !resp_empty && !flush_i;

  assign req_push = req_valid_i && req_ready_o;
  assign req_pop  = core_req_valid_o && core_req_ready_i;
  assign resp_pop = resp_valid_o && resp_ready_i;
  assign cresp_hs = core_resp_valid_i && core_resp_ready_o;

  // A response is only wanted if some issued request has no reply queued.
  assign pending_nz = 32'(outstanding_o) > 32'(resp_count);
  assign resp_push  = cresp_hs && pending_nz;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (flush_i),
    .push  (req_push),
    .pop   (req_pop),
    .wdata (req_data_i),
    .rdata (core_req_data_o),
    .full  (req_full),
    .empty (req_empty),
    .count (req_count)
  );

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (flush_i),
    .push  (resp_push),
    .pop   (resp_pop),
    .wdata (core_resp_data_i),
    .rdata (resp_data_o),
    .full  (resp_full),
    .empty (resp_empty),
    .count (resp_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      outstanding_o <= '0;
      unexp_resp_o  <= 1'b0;
    end else begin
      unexp_resp_o <= cresp_hs && !pending_nz;
      if (req_pop && !resp_pop) begin
        outstanding_o <= outstanding_o + OW'(1);
      end else if (resp_pop && !req_pop) begin
        outstanding_o <= outstanding_o - OW'(1);
      end
    end
  end

  a_req_count: assert property (@(posedge clk_i) disable iff (rst_i)
    32'(req_count) <= REQ_DEPTH);

endmodule

// File: tb/tb_dmi_chan_buf.sv
// Self-checking bench for dmi_chan_buf: vector table, corner sequences
// and a randomized run against a queue-based reference model.
module tb_dmi_chan_buf;

  localparam int W = 41;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, flush, req_valid, core_ready, cresp_valid, resp_ready;
  logic [W-1:0] req_data, cresp_data;
  logic         req_ready, core_valid, cresp_ready, resp_valid, unexp;
  logic [W-1:0] core_data, resp_data;
  logic [2:0]   os;

  logic         b_flush, b_req_valid, b_core_ready, b_cresp_valid, b_resp_ready;
  logic [W-1:0] b_req_data, b_cresp_data;
  logic         b_req_ready, b_core_valid, b_cresp_ready, b_resp_valid, b_unexp;
  logic [W-1:0] b_core_data, b_resp_data;
  logic [1:0]   b_os;

  dmi_chan_buf dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .flush_i           (flush),
    .req_data_i        (req_data),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .resp_data_o       (resp_data),
    .resp_valid_o      (resp_valid),
    .resp_ready_i      (resp_ready),
    .core_req_data_o   (core_data),
    .core_req_valid_o  (core_valid),
    .core_req_ready_i  (core_ready),
    .core_resp_data_i  (cresp_data),
    .core_resp_valid_i (cresp_valid),
    .core_resp_ready_o (cresp_ready),
    .outstanding_o     (os),
    .unexp_resp_o      (unexp)
  );

  dmi_chan_buf #(.MAX_OUTSTANDING(2)) dut2 (
    .clk_i             (clk),
    .rst_i             (rst),
    .flush_i           (b_flush),
    .req_data_i        (b_req_data),
    .req_valid_i       (b_req_valid),
    .req_ready_o       (b_req_ready),
    .resp_data_o       (b_resp_data),
    .resp_valid_o      (b_resp_valid),
    .resp_ready_i      (b_resp_ready),
    .core_req_data_o   (b_core_data),
    .core_req_valid_o  (b_core_valid),
    .core_req_ready_i  (b_core_ready),
    .core_resp_data_i  (b_cresp_data),
    .core_resp_valid_i (b_cresp_valid),
    .core_resp_ready_o (b_cresp_ready),
    .outstanding_o     (b_os),
    .unexp_resp_o      (b_unexp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    flush = 0; req_valid = 0; req_data = '0; core_ready = 0;
    cresp_valid = 0; cresp_data = '0; resp_ready = 0;
    b_flush = 0; b_req_valid = 0; b_req_data = '0; b_core_ready = 0;
    b_cresp_valid = 0; b_cresp_data = '0; b_resp_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  typedef struct {
    logic         fl, rv;
    logic [W-1:0] rd;
    logic         cr, cv;
    logic [W-1:0] cd;
    logic         rr;
    logic         e_rdy, e_crr, e_cv;
    logic [W-1:0] e_cd;
    logic [2:0]   e_os;
    logic         e_rv;
    logic [W-1:0] e_rd;
    logic         e_un;
  } vec_t;

  vec_t tbl[10];

  // Reference model state for the randomized run.
  logic [W-1:0] mq_req[$];
  logic [W-1:0] mq_resp[$];
  int           m_os;
  logic         m_un;

  initial begin
    logic [W-1:0] got[$];
    rst = 0;
    idle();
    tick();

    tbl[0] = '{0,0,'h0,  0,0,'h0,  0, 1,1,0,'h0, 0,0,'h0,  0};
    tbl[1] = '{0,1,'h11, 0,0,'h0,  0, 1,1,0,'h0, 0,0,'h0,  0};
    tbl[2] = '{0,1,'h22, 1,0,'h0,  0, 1,1,1,'h11,0,0,'h0,  0};
    tbl[3] = '{0,0,'h0,  1,1,'hA5, 0, 1,1,1,'h22,1,0,'h0,  0};
    tbl[4] = '{0,0,'h0,  0,0,'h0,  1, 1,1,0,'h0, 2,1,'hA5, 0};
    tbl[5] = '{0,0,'h0,  0,1,'hB6, 0, 1,1,0,'h0, 1,0,'h0,  0};
    tbl[6] = '{0,0,'h0,  0,1,'hC7, 0, 1,1,0,'h0, 1,1,'hB6, 0};
    tbl[7] = '{0,0,'h0,  0,0,'h0,  1, 1,1,0,'h0, 1,1,'hB6, 1};
    tbl[8] = '{1,1,'h33, 0,0,'h0,  0, 0,0,0,'h0, 0,0,'h0,  0};
    tbl[9] = '{0,0,'h0,  0,0,'h0,  0, 1,1,0,'h0, 0,0,'h0,  0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      flush = tbl[i].fl; req_valid = tbl[i].rv; req_data = tbl[i].rd;
      core_ready = tbl[i].cr; cresp_valid = tbl[i].cv;
      cresp_data = tbl[i].cd; resp_ready = tbl[i].rr;
      #1;
      chk($sformatf("v%0d_req_ready", i), 64'(req_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("v%0d_cresp_ready", i), 64'(cresp_ready), 64'(tbl[i].e_crr));
      chk($sformatf("v%0d_core_valid", i), 64'(core_valid), 64'(tbl[i].e_cv));
      if (tbl[i].e_cv)
        chk($sformatf("v%0d_core_data", i), 64'(core_data), 64'(tbl[i].e_cd));
      chk($sformatf("v%0d_outstanding", i), 64'(os), 64'(tbl[i].e_os));
      chk($sformatf("v%0d_resp_valid", i), 64'(resp_valid), 64'(tbl[i].e_rv));
      if (tbl[i].e_rv)
        chk($sformatf("v%0d_resp_data", i), 64'(resp_data), 64'(tbl[i].e_rd));
      chk($sformatf("v%0d_unexp", i), 64'(unexp), 64'(tbl[i].e_un));
      tick();
    end

    // Full request FIFO refuses a fifth word; one pop re-opens it.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req_valid = 1; req_data = W'(32'h100 + k);
      #1 chk("fill_ready", 64'(req_ready), 1);
      tick();
    end
    req_data = W'(32'h1FF);
    #1 chk("full_ready", 64'(req_ready), 0);
    tick();
    req_valid = 0; core_ready = 1;
    #1 chk("full_head", 64'(core_data), 64'h100);
    tick();
    core_ready = 0;
    #1 chk("ready_after_pop", 64'(req_ready), 1);
    core_ready = 1;
    for (int k = 1; k < 4; k++) begin
      #1 chk("drain_order", 64'(core_data), 64'(32'h100 + k));
      tick();
    end
    core_ready = 0; cresp_valid = 1; cresp_data = W'(32'h55);
    #1 chk("os_at_max", 64'(os), 4);
    tick();
    cresp_valid = 0; resp_ready = 1;
    #1 chk("resp_55", 64'(resp_data), 64'h55);
    tick();
    resp_ready = 0;
    #1 chk("no_fifth_valid", 64'(core_valid), 0);
    chk("os_after_resp", 64'(os), 3);

    // Two responses, ready toggling, data held while stalled.
    do_reset();
    core_ready = 1; req_valid = 1; req_data = W'(1);
    tick();
    req_data = W'(2);
    tick();
    req_valid = 0;
    tick();
    core_ready = 0;
    #1 chk("os_two", 64'(os), 2);
    cresp_valid = 1; cresp_data = W'('hA);
    tick();
    cresp_data = W'('hB);
    tick();
    cresp_valid = 0;
    resp_ready = 1;
    #1 chk("rsp0_data", 64'(resp_data), 64'hA);
    tick();
    resp_ready = 0;
    #1 chk("rsp1_stall_data", 64'(resp_data), 64'hB);
    chk("rsp1_stall_valid", 64'(resp_valid), 1);
    tick();
    resp_ready = 1;
    #1 chk("rsp1_data", 64'(resp_data), 64'hB);
    tick();
    resp_ready = 0;
    #1 chk("rsp_done_valid", 64'(resp_valid), 0);
    chk("rsp_done_os", 64'(os), 0);

    // Response with nothing outstanding is dropped and flagged once.
    do_reset();
    cresp_valid = 1; cresp_data = W'('h77);
    tick();
    cresp_valid = 0;
    #1 chk("unexp_pulse", 64'(unexp), 1);
    chk("unexp_dropped", 64'(resp_valid), 0);
    tick();
    #1 chk("unexp_once", 64'(unexp), 0);

    // Flush with three queued and one issued.
    do_reset();
    req_valid = 1;
    for (int k = 0; k < 4; k++) begin
      req_data = W'(32'h201 + k);
      tick();
    end
    req_valid = 0; core_ready = 1;
    tick();
    core_ready = 0; flush = 1;
    #1 chk("flush_req_ready", 64'(req_ready), 0);
    chk("flush_core_valid", 64'(core_valid), 0);
    tick();
    flush = 0;
    #1 chk("post_flush_cv", 64'(core_valid), 0);
    chk("post_flush_rv", 64'(resp_valid), 0);
    chk("post_flush_os", 64'(os), 0);
    cresp_valid = 1; cresp_data = W'('h99);
    tick();
    cresp_valid = 0;
    #1 chk("late_resp_unexp", 64'(unexp), 1);
    chk("late_resp_rv", 64'(resp_valid), 0);

    // Reset in the middle of traffic, then a fresh request.
    do_reset();
    core_ready = 1; req_valid = 1; req_data = W'('h301);
    tick();
    req_data = W'('h302);
    tick();
    cresp_valid = 1; cresp_data = W'('h3AA); rst = 1;
    tick();
    rst = 0; req_valid = 0; cresp_valid = 0;
    #1 chk("rst_req_ready", 64'(req_ready), 1);
    chk("rst_cresp_ready", 64'(cresp_ready), 1);
    chk("rst_core_valid", 64'(core_valid), 0);
    chk("rst_resp_valid", 64'(resp_valid), 0);
    chk("rst_unexp", 64'(unexp), 0);
    chk("rst_os", 64'(os), 0);
    req_valid = 1; req_data = W'(7);
    #1 chk("fresh_same_cycle", 64'(core_valid), 0);
    tick();
    req_valid = 0;
    #1 chk("fresh_valid", 64'(core_valid), 1);
    chk("fresh_data", 64'(core_data), 64'h7);
    tick();

    // MAX_OUTSTANDING=2 instance: only two requests issue.
    do_reset();
    b_core_ready = 1;
    for (int k = 0; k < 8; k++) begin
      b_req_valid = (k < 4);
      b_req_data = W'(k + 1);
      #1;
      if (b_core_valid && b_core_ready) got.push_back(b_core_data);
      tick();
    end
    b_req_valid = 0;
    #1 chk("lim_hs_count", 64'(got.size()), 2);
    if (got.size() >= 2) begin
      chk("lim_hs0", 64'(got[0]), 64'h1);
      chk("lim_hs1", 64'(got[1]), 64'h2);
    end
    chk("lim_os", 64'(b_os), 2);
    for (int k = 0; k < 2; k++) begin
      b_req_valid = 1; b_req_data = W'(5 + k);
      #1 chk("lim_room", 64'(b_req_ready), 1);
      tick();
    end
    b_req_valid = 0;
    #1 chk("lim_held_two", 64'(b_req_ready), 0);

    // Randomized run against the queue model.
    do_reset();
    mq_req.delete(); mq_resp.delete(); m_os = 0; m_un = 0;
    for (int c = 0; c < 3000; c++) begin
      logic e_rdy, e_cv, e_crr, e_rv;
      int   pend;
      flush       = ($urandom_range(0, 39) == 0);
      req_valid   = 1'($urandom_range(0, 1));
      req_data    = W'({$urandom(), $urandom()});
      core_ready  = 1'($urandom_range(0, 1));
      cresp_valid = ($urandom_range(0, 2) == 0);
      cresp_data  = W'({$urandom(), $urandom()});
      resp_ready  = 1'($urandom_range(0, 1));
      #1;
      e_rdy = (mq_req.size() < 4) && !flush;
      e_cv  = (mq_req.size() > 0) && (m_os < 4) && !flush;
      e_crr = (mq_resp.size() < 4) && !flush;
      e_rv  = (mq_resp.size() > 0) && !flush;
      chk("rnd_req_ready", 64'(req_ready), 64'(e_rdy));
      chk("rnd_core_valid", 64'(core_valid), 64'(e_cv));
      if (e_cv) chk("rnd_core_data", 64'(core_data), 64'(mq_req[0]));
      chk("rnd_cresp_ready", 64'(cresp_ready), 64'(e_crr));
      chk("rnd_resp_valid", 64'(resp_valid), 64'(e_rv));
      if (e_rv) chk("rnd_resp_data", 64'(resp_data), 64'(mq_resp[0]));
      chk("rnd_os", 64'(os), 64'(m_os));
      chk("rnd_unexp", 64'(unexp), 64'(m_un));
      m_un = 0;
      if (flush) begin
        mq_req.delete(); mq_resp.delete(); m_os = 0;
      end else begin
        pend = m_os - mq_resp.size();
        if (e_cv && core_ready) begin
          void'(mq_req.pop_front());
          m_os++;
        end
        if (e_rv && resp_ready) begin
          void'(mq_resp.pop_front());
          m_os--;
        end
        if (req_valid && e_rdy) mq_req.push_back(req_data);
        if (cresp_valid && e_crr) begin
          if (pend > 0) mq_resp.push_back(cresp_data);
          else m_un = 1;
        end
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
